buffer_w_pingpong: RTL and testbench

// Double-buffered (ping-pong) weight buffer between the weight load engine and the MM array.
// Two RAM banks: load fills one bank while MM streams the other; banks swap by done handshakes.

---
 rtl/buffer_w_pingpong.sv | 196 +++++++++++++++++++
 tb/tb_buffer_w_pingpong.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_w_pingpong.sv
// buffer_w_pingpong: two-bank (ping-pong) weight buffer. The load engine fills one bank while
// the MM array streams the other; ownership swaps on load_done / mm_done handshakes. A released
// bank stays blocked for writes until every read issued before mm_done has drained.
module buffer_w_pingpong #(
    parameter int BUFFER_ADDR_WIDTH  = 13,
    parameter int BUFFER_DATA_WIDTH  = 8192,
    parameter int RAM_LATENCY        = 2,
    parameter     MEM_POOL_PRIMITIVE = "auto"
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_write_addr_valid,
    input  logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0] load_write_data,
    input  logic                         load_done,
    output logic                         load_ready,
    input  logic                         mm_read_addr_valid,
    input  logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr,
    input  logic                         mm_done,
    output logic                         mm_ready,
    output logic                         mm_read_data_valid,
    output logic [BUFFER_DATA_WIDTH-1:0] mm_read_data,
    output logic                         wr_err,
    output logic                         rd_err
);

    // Release drain window = full read pipeline depth (addr reg + RAM + output reg).
    localparam int DRAIN = RAM_LATENCY + 2;
    localparam int CW    = $clog2(DRAIN);

    if (RAM_LATENCY < 1) begin : g_bad_latency
        $error("buffer_w_pingpong: RAM_LATENCY must be at least 1");
    end

    if (!(MEM_POOL_PRIMITIVE == "auto"  || MEM_POOL_PRIMITIVE == "ultra" ||
          MEM_POOL_PRIMITIVE == "block" || MEM_POOL_PRIMITIVE == "distributed")) begin : g_bad_primitive
        $error("buffer_w_pingpong: unsupported MEM_POOL_PRIMITIVE");
    end

    logic                         r_wr_ptr;
    logic                         r_rd_ptr;
    logic                         r_wr_en;
    logic                         r_wr_bank;
    logic                         r_ld_done;
    logic [BUFFER_ADDR_WIDTH-1:0] r_wr_addr;
    logic [BUFFER_DATA_WIDTH-1:0] r_wr_data;
    logic                         r_wr_err;
    logic                         r_rd_err;

    logic                         r_rd_v1;
    logic                         r_rd_bank1;
    logic [BUFFER_ADDR_WIDTH-1:0] r_rd_addr1;
    logic [RAM_LATENCY-1:0]       r_pipe_v;
    logic [RAM_LATENCY-1:0]       r_pipe_bank;
    logic                         r_out_valid;
    logic [BUFFER_DATA_WIDTH-1:0] r_out_data;

    logic [1:0]                   w_full;
    logic [1:0]                   w_rel_pend;
    logic [BUFFER_DATA_WIDTH-1:0] w_bank_q [2];
    logic                         w_load_ready;
    logic                         w_mm_ready;
    logic                         w_wr_acc;
    logic                         w_ld_acc;
    logic                         w_rd_acc;
    logic                         w_mm_acc;

    // A bank being drained after mm_done is still full but must not accept new writes.
    assign w_load_ready = !w_full[r_wr_ptr] && !w_rel_pend[r_wr_ptr];
    assign w_mm_ready   = w_full[r_rd_ptr];
    assign w_wr_acc     = load_write_addr_valid && w_load_ready;
    assign w_ld_acc     = load_done && w_load_ready;
    assign w_rd_acc     = mm_read_addr_valid && w_mm_ready;
    assign w_mm_acc     = mm_done && w_mm_ready;

    assign load_ready         = w_load_ready;
    assign mm_ready           = w_mm_ready;
    assign mm_read_data_valid = r_out_valid;
    assign mm_read_data       = r_out_data;
    assign wr_err             = r_wr_err;
    assign rd_err             = r_rd_err;

    // Bank pointers, write-stage control, read-stage control and sticky protocol errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_ld_done   <= 1'b0;
            r_wr_err    <= 1'b0;
            r_rd_err    <= 1'b0;
            r_rd_v1     <= 1'b0;
            r_rd_bank1  <= 1'b0;
            r_pipe_v    <= '0;
            r_pipe_bank <= '0;
        end else begin
            r_wr_en    <= w_wr_acc;
            r_ld_done  <= w_ld_acc;
            r_wr_bank  <= r_wr_ptr;
            r_rd_v1    <= w_rd_acc;
            r_rd_bank1 <= r_rd_ptr;
            if (w_ld_acc) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_mm_acc) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if ((load_write_addr_valid || load_done) && !w_load_ready) begin
                r_wr_err <= 1'b1;
            end
            if ((mm_read_addr_valid || mm_done) && !w_mm_ready) begin
                r_rd_err <= 1'b1;
            end
            r_pipe_v[0]    <= r_rd_v1;
            r_pipe_bank[0] <= r_rd_bank1;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_bank[i] <= r_pipe_bank[i-1];
            end
        end
    end

    // Address/data capture for the write and read stages; only loaded on accepted strobes.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_wr_addr <= load_write_addr;
            r_wr_data <= load_write_data;
        end
        if (w_rd_acc) begin
            r_rd_addr1 <= mm_read_addr;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic [BUFFER_DATA_WIDTH-1:0] r_mem   [2**BUFFER_ADDR_WIDTH];
        logic [BUFFER_DATA_WIDTH-1:0] r_ram_q [RAM_LATENCY];
        logic                         r_full;
        logic                         r_rel_pend;
        logic [CW-1:0]                r_rel_cnt;

        // Ownership flags: full lands with the last write commit; release drains via down-counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_full     <= 1'b0;
                r_rel_pend <= 1'b0;
                r_rel_cnt  <= '0;
            end else begin
                if (r_ld_done && r_wr_bank == 1'(g)) begin
                    r_full <= 1'b1;
                end
                if (w_mm_acc && r_rd_ptr == 1'(g)) begin
                    r_rel_pend <= 1'b1;
                    r_rel_cnt  <= CW'(DRAIN - 1);
                end else if (r_rel_pend) begin
                    if (r_rel_cnt == CW'(1)) begin
                        r_full     <= 1'b0;
                        r_rel_pend <= 1'b0;
                        r_rel_cnt  <= '0;
                    end else begin
                        r_rel_cnt <= r_rel_cnt - 1'b1;
                    end
                end
            end
        end

        // Simple dual-port bank RAM with a RAM_LATENCY-deep registered read path.
        always_ff @(posedge clk) begin
            if (r_wr_en && r_wr_bank == 1'(g)) begin
                r_mem[r_wr_addr] <= r_wr_data;
            end
            if (r_rd_v1 && r_rd_bank1 == 1'(g)) begin
                r_ram_q[0] <= r_mem[r_rd_addr1];
            end
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_ram_q[i] <= r_ram_q[i-1];
            end
        end

        assign w_full[g]     = r_full;
        assign w_rel_pend[g] = r_rel_pend;
        assign w_bank_q[g]   = r_ram_q[RAM_LATENCY-1];
    end

    // Output register: bank id carried down the pipe picks the source; data forced to 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_pipe_v[RAM_LATENCY-1];
            r_out_data  <= r_pipe_v[RAM_LATENCY-1] ? w_bank_q[r_pipe_bank[RAM_LATENCY-1]] : '0;
        end
    end

endmodule

// File: tb/tb_buffer_w_pingpong.sv
// tb_buffer_w_pingpong: directed scenarios plus randomized traffic against an event-time model
// of the ping-pong buffer (bank contents, ownership flags, scheduled read returns).
module tb_buffer_w_pingpong;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int NB   = 1 << AW;
    localparam int MAXE = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_write_addr_valid = 1'b0;
    logic [AW-1:0] load_write_addr = '0;
    logic [DW-1:0] load_write_data = '0;
    logic          load_done = 1'b0;
    logic          load_ready;
    logic          mm_read_addr_valid = 1'b0;
    logic [AW-1:0] mm_read_addr = '0;
    logic          mm_done = 1'b0;
    logic          mm_ready;
    logic          mm_read_data_valid;
    logic [DW-1:0] mm_read_data;
    logic          wr_err;
    logic          rd_err;

    always #5 clk = ~clk;

    buffer_w_pingpong #(
        .BUFFER_ADDR_WIDTH (AW),
        .BUFFER_DATA_WIDTH (DW),
        .RAM_LATENCY       (LAT),
        .MEM_POOL_PRIMITIVE("auto")
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .load_write_addr_valid(load_write_addr_valid),
        .load_write_addr      (load_write_addr),
        .load_write_data      (load_write_data),
        .load_done            (load_done),
        .load_ready           (load_ready),
        .mm_read_addr_valid   (mm_read_addr_valid),
        .mm_read_addr         (mm_read_addr),
        .mm_done              (mm_done),
        .mm_ready             (mm_ready),
        .mm_read_data_valid   (mm_read_data_valid),
        .mm_read_data         (mm_read_data),
        .wr_err               (wr_err),
        .rd_err               (rd_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0b, expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (edge-indexed) ----------------
    int            e_now = 0;
    bit            m_wp, m_rp;
    bit            m_full [2];
    bit            m_pend [2];
    int            m_full_at [2];
    int            m_rel_at [2];
    bit            m_werr, m_rerr;
    logic [DW-1:0] m_mem   [2][NB];
    bit            m_known [2][NB];
    bit            expv [MAXE];
    bit            expk [MAXE];
    logic [DW-1:0] expd [MAXE];

    // expectations for the outputs right after the upcoming edge
    bit            x_lr = 1'b1, x_mr = 1'b0, x_v = 1'b0, x_k = 1'b1, x_we = 1'b0, x_re = 1'b0;
    logic [DW-1:0] x_d = '0;

    function automatic bit m_lr();
        return !m_full[m_wp] && !m_pend[m_wp];
    endfunction

    function automatic bit m_mr();
        return m_full[m_rp];
    endfunction

    function automatic void m_reset();
        m_wp = 1'b0; m_rp = 1'b0; m_werr = 1'b0; m_rerr = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_full[b] = 1'b0; m_pend[b] = 1'b0; m_full_at[b] = -1; m_rel_at[b] = -1;
            for (int a = 0; a < NB; a++) m_known[b][a] = 1'b0;
        end
        for (int i = e_now + 1; i < MAXE; i++) expv[i] = 1'b0;
    endfunction

    function automatic void m_step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                   input bit ld, input bit rv, input logic [AW-1:0] ra, input bit md);
        int e;
        bit lr, mr;
        e  = e_now + 1;
        lr = m_lr();
        mr = m_mr();
        if ((wv || ld) && !lr) m_werr = 1'b1;
        if ((rv || md) && !mr) m_rerr = 1'b1;
        if (wv && lr) begin
            m_mem[m_wp][wa]   = wd;
            m_known[m_wp][wa] = 1'b1;
        end
        if (rv && mr) begin
            expv[e + LAT + 1] = 1'b1;
            expk[e + LAT + 1] = m_known[m_rp][ra];
            expd[e + LAT + 1] = m_mem[m_rp][ra];
        end
        if (ld && lr) begin
            m_full_at[m_wp] = e + 1;
            m_wp = !m_wp;
        end
        if (md && mr) begin
            m_pend[m_rp]   = 1'b1;
            m_rel_at[m_rp] = e + LAT + 1;
            m_rp = !m_rp;
        end
        for (int b = 0; b < 2; b++) begin
            if (m_full_at[b] == e) begin
                m_full[b] = 1'b1;
                m_full_at[b] = -1;
            end
            if (m_pend[b] && m_rel_at[b] == e) begin
                m_full[b] = 1'b0;
                m_pend[b] = 1'b0;
            end
        end
        e_now = e;
        x_lr = m_lr();
        x_mr = m_mr();
        x_v  = expv[e];
        x_k  = expv[e] ? expk[e] : 1'b1;
        x_d  = expv[e] ? expd[e] : '0;
        x_we = m_werr;
        x_re = m_rerr;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(posedge clk) begin
        #1;
        chk1("load_ready", load_ready, x_lr);
        chk1("mm_ready", mm_ready, x_mr);
        chk1("mm_read_data_valid", mm_read_data_valid, x_v);
        if (x_k) chkd("mm_read_data", mm_read_data, x_d);
        chk1("wr_err", wr_err, x_we);
        chk1("rd_err", rd_err, x_re);
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic tick(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit ld, input bit rv, input logic [AW-1:0] ra, input bit md);
        rst_n                 = 1'b1;
        load_write_addr_valid = wv;
        load_write_addr       = wa;
        load_write_data       = wd;
        load_done             = ld;
        mm_read_addr_valid    = rv;
        mm_read_addr          = ra;
        mm_done               = md;
        m_step(wv, wa, wd, ld, rv, ra, md);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rst_tick();
        rst_n                 = 1'b0;
        load_write_addr_valid = 1'b0;
        load_done             = 1'b0;
        mm_read_addr_valid    = 1'b0;
        mm_done               = 1'b0;
        m_reset();
        e_now = e_now + 1;
        x_lr = 1'b1; x_mr = 1'b0; x_v = 1'b0; x_k = 1'b1; x_d = '0; x_we = 1'b0; x_re = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit            wv, ld, rv, md;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NB; a++) m_mem[b][a] = '0;

        // 1: reset
        rst_tick();
        rst_tick();
        idle(1);
        chk1("t1 load_ready", load_ready, 1'b1);
        chk1("t1 mm_ready", mm_ready, 1'b0);
        chk1("t1 valid", mm_read_data_valid, 1'b0);
        chk1("t1 wr_err", wr_err, 1'b0);
        chk1("t1 rd_err", rd_err, 1'b0);
        chk1("t1 model load_ready", x_lr, 1'b1);

        // 2: fill bank0 with A0..A3, load_done on last write, read back
        for (int i = 0; i < 4; i++)
            tick(1'b1, AW'(i), DW'(16'hA0 + i), (i == 3), 1'b0, '0, 1'b0);
        chk1("t2 mm_ready early", mm_ready, 1'b0);
        idle(1);
        chk1("t2 mm_ready", mm_ready, 1'b1);
        chk1("t2 model mm_ready", x_mr, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
            if (i < 3) chk1("t2 valid early", mm_read_data_valid, 1'b0);
        end
        chk1("t2 valid0", mm_read_data_valid, 1'b1);
        chkd("t2 data0", mm_read_data, 16'h00A0);
        chkd("t2 model data0", x_d, 16'h00A0);
        for (int i = 1; i < 4; i++) begin
            idle(1);
            chk1("t2 valid", mm_read_data_valid, 1'b1);
            chkd("t2 data", mm_read_data, DW'(16'hA0 + i));
        end
        idle(1);
        chk1("t2 valid end", mm_read_data_valid, 1'b0);
        chkd("t2 data end", mm_read_data, 16'h0000);

        // 3: fill bank1 while streaming bank0
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, AW'(i), DW'(16'hB0 + i), (i == 3), 1'b1, AW'(i), 1'b0);
            if (i < 3) chk1("t3 no stall", load_ready, 1'b1);
        end
        chk1("t3 both full", load_ready, 1'b0);
        idle(4);
        chk1("t3 mm_ready", mm_ready, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk1("t3 ld_rdy after done", load_ready, 1'b0);
        idle(2);
        chk1("t3 ld_rdy draining", load_ready, 1'b0);
        idle(1);
        chk1("t3 ld_rdy released", load_ready, 1'b1);
        chk1("t3 model released", x_lr, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1, AW'(2), 1'b0);
        idle(3);
        chk1("t3 bank1 valid", mm_read_data_valid, 1'b1);
        chkd("t3 bank1 data", mm_read_data, 16'h00B2);

        // 5: mm_done one cycle after last read
        tick(1'b0, '0, '0, 1'b0, 1'b1, AW'(3), 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk1("t5 mm_ready after done", mm_ready, 1'b0);
        idle(2);
        chk1("t5 valid", mm_read_data_valid, 1'b1);
        chkd("t5 old data", mm_read_data, 16'h00B3);
        idle(4);

        // 4: protocol errors
        tick(1'b0, '0, '0, 1'b0, 1'b1, AW'(5), 1'b0);
        chk1("t4 rd_err", rd_err, 1'b1);
        idle(3);
        chk1("t4 no valid", mm_read_data_valid, 1'b0);
        tick(1'b1, AW'(0), 16'h0011, 1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, AW'(0), 16'h0022, 1'b1, 1'b0, '0, 1'b0);
        idle(1);
        chk1("t4 load_ready", load_ready, 1'b0);
        chk1("t4 wr_err clean", wr_err, 1'b0);
        tick(1'b1, AW'(0), 16'h00EE, 1'b0, 1'b0, '0, 1'b0);
        chk1("t4 wr_err", wr_err, 1'b1);
        idle(1);
        tick(1'b0, '0, '0, 1'b0, 1'b1, AW'(0), 1'b0);
        idle(3);
        chkd("t4 ram unchanged", mm_read_data, 16'h0011);

        // 6: reset with three reads in flight
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
        rst_tick();
        chk1("t6 mm_ready", mm_ready, 1'b0);
        chk1("t6 load_ready", load_ready, 1'b1);
        chk1("t6 wr_err", wr_err, 1'b0);
        chk1("t6 rd_err", rd_err, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk1("t6 no valid", mm_read_data_valid, 1'b0);
        end

        // randomized traffic, mostly protocol-respecting, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_tick();
            end else begin
                wv = m_lr() ? ($urandom_range(0, 3) != 0)  : ($urandom_range(0, 49) == 0);
                ld = m_lr() ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 99) == 0);
                rv = m_mr() ? ($urandom_range(0, 2) != 0)  : ($urandom_range(0, 49) == 0);
                md = m_mr() ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 99) == 0);
                wa = AW'($urandom_range(0, NB - 1));
                ra = AW'($urandom_range(0, NB - 1));
                wd = DW'($urandom);
                tick(wv, wa, wd, ld, rv, ra, md);
            end
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
